// File: rtl/netlist_tb_pkg.sv
// Shared constants, FSM states and LFSR/slice helpers for the OAI slice stimulus checker.
package netlist_tb_pkg;

   localparam int WIDTH   = 41;
   localparam int SLICES  = 9;
   localparam int SLICE_W = 4;
   localparam int CHK_W   = SLICES * SLICE_W;
   localparam int LFSR_W  = 72;

   // Taps for x^72 + x^66 + x^25 + x^19 + 1 (bit index = exponent - 1)
   localparam int TAP_0 = 71;
   localparam int TAP_1 = 65;
   localparam int TAP_2 = 24;
   localparam int TAP_3 = 18;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3]};
   endfunction

   function automatic logic [SLICES-1:0] slice_fold(input logic [CHK_W-1:0] diff);
      logic [SLICES-1:0] r;
      r = '0;
      for (int k = 0; k < SLICES; k++) begin
         r[k] = |diff[k*SLICE_W +: SLICE_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/oai_slice_ref.sv
// Combinational golden model of the nine 4-bit OAI slices across the checked 36 bits.
module oai_slice_ref
   import netlist_tb_pkg::*;
(
   input  logic [CHK_W-1:0] a_i,
   input  logic [CHK_W-1:0] b_i,
   output logic [CHK_W-1:0] exp_o
);

   always_comb begin
      exp_o = '0;
      for (int k = 0; k < SLICES; k++) begin
         exp_o[k*SLICE_W]     = ~a_i[k*SLICE_W];
         exp_o[k*SLICE_W + 1] = ~b_i[k*SLICE_W];
         exp_o[k*SLICE_W + 2] = ~b_i[k*SLICE_W + 1];
         exp_o[k*SLICE_W + 3] = ~((a_i[k*SLICE_W + 1] | a_i[k*SLICE_W + 2]) &
                                  (b_i[k*SLICE_W + 1] | b_i[k*SLICE_W + 2]) &
                                  (a_i[k*SLICE_W + 3] | b_i[k*SLICE_W + 3]));
      end
   end

endmodule

// File: rtl/oai_slice_stim_checker.sv
// Drives LFSR vectors into an OAI slice netlist and checks its response one cycle later,
// accumulating mismatch count, first failing index and a sticky failing-slice mask.
module oai_slice_stim_checker
   import netlist_tb_pkg::*;
#(
   parameter int unsigned       NUM_VECTORS = 256,
   parameter logic [LFSR_W-1:0] SEED        = 72'h5A5A_0F0F_1234_89AB_CD
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       mismatch_count,
   output logic [15:0]       first_fail_idx,
   output logic [SLICES-1:0] fail_slice_mask,
   output logic [WIDTH-1:0]  a_o,
   output logic [WIDTH-1:0]  b_o,
   input  logic [WIDTH-1:0]  c_i
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] NO_FAIL  = 16'hFFFF;

   state_t              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [15:0]         vec_idx_q, vec_idx_d;
   logic [CHK_W-1:0]    exp_q, exp_d;
   logic                exp_valid_q, exp_valid_d;
   logic [15:0]         exp_idx_q, exp_idx_d;
   logic [15:0]         mismatch_count_q, mismatch_count_d;
   logic [15:0]         first_fail_idx_q, first_fail_idx_d;
   logic [SLICES-1:0]   mask_q, mask_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;

   logic [CHK_W-1:0]    exp_now;
   logic [SLICES-1:0]   slice_fail;
   logic                unused_c_hi;

   oai_slice_ref u_ref (
      .a_i   (lfsr_q[CHK_W-1:0]),
      .b_i   (lfsr_q[LFSR_W-1:CHK_W]),
      .exp_o (exp_now)
   );

   assign unused_c_hi = ^c_i[WIDTH-1:CHK_W];

   always_comb begin
      slice_fail = slice_fold(c_i[CHK_W-1:0] ^ exp_q);
   end

   always_comb begin
      state_d          = state_q;
      lfsr_d           = lfsr_q;
      vec_idx_d        = vec_idx_q;
      exp_d            = exp_q;
      exp_valid_d      = 1'b0;
      exp_idx_d        = exp_idx_q;
      mismatch_count_d = mismatch_count_q;
      first_fail_idx_d = first_fail_idx_q;
      mask_d           = mask_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      pass_d           = pass_q;

      // Compare stage sees the vector presented in the previous cycle
      if (exp_valid_q && (slice_fail != '0)) begin
         if (mismatch_count_q != 16'hFFFF) begin
            mismatch_count_d = mismatch_count_q + 16'd1;
         end
         if (first_fail_idx_q == NO_FAIL) begin
            first_fail_idx_d = exp_idx_q;
         end
         mask_d = mask_q | slice_fail;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d          = RUN;
               lfsr_d           = SEED;
               vec_idx_d        = 16'd0;
               mismatch_count_d = 16'd0;
               first_fail_idx_d = NO_FAIL;
               mask_d           = '0;
               busy_d           = 1'b1;
            end
         end
         RUN: begin
            exp_d       = exp_now;
            exp_valid_d = 1'b1;
            exp_idx_d   = vec_idx_q;
            lfsr_d      = lfsr_step(lfsr_q);
            vec_idx_d   = vec_idx_q + 16'd1;
            if (vec_idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mismatch_count_d == 16'd0);
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         lfsr_q           <= SEED;
         vec_idx_q        <= 16'd0;
         exp_q            <= '0;
         exp_valid_q      <= 1'b0;
         exp_idx_q        <= 16'd0;
         mismatch_count_q <= 16'd0;
         first_fail_idx_q <= NO_FAIL;
         mask_q           <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         lfsr_q           <= lfsr_d;
         vec_idx_q        <= vec_idx_d;
         exp_q            <= exp_d;
         exp_valid_q      <= exp_valid_d;
         exp_idx_q        <= exp_idx_d;
         mismatch_count_q <= mismatch_count_d;
         first_fail_idx_q <= first_fail_idx_d;
         mask_q           <= mask_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
      end
   end

   // Stimulus is only driven while vectors are being presented
   assign a_o = (state_q == RUN) ? {{(WIDTH-CHK_W){1'b0}}, lfsr_q[CHK_W-1:0]} : '0;
   assign b_o = (state_q == RUN) ? {{(WIDTH-CHK_W){1'b0}}, lfsr_q[LFSR_W-1:CHK_W]} : '0;

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign mismatch_count  = mismatch_count_q;
   assign first_fail_idx  = first_fail_idx_q;
   assign fail_slice_mask = mask_q;

endmodule

// File: tb/tb_oai_slice_stim_checker.sv
// Scoreboard bench: plays a latency-1 OAI netlist (with optional planted faults) against the checker.
module tb_oai_slice_stim_checker;

   localparam int          N    = 256;
   localparam logic [71:0] SEED = 72'h5A5A_0F0F_1234_89AB_CD;

   typedef struct {
      int          start_cyc;
      logic        pass;
      logic [15:0] count;
      logic [15:0] first;
      logic [8:0]  mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start1;
   logic        busy, done, pass, busy1, done1, pass1;
   logic [15:0] mcount, ffidx, mcount1, ffidx1;
   logic [8:0]  fmask, fmask1;
   logic [40:0] a_o, b_o, c_q, a1, b1, c1_q;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          fault_mode = 0;
   bit          chk_stim = 0;
   int          run_idx = 0;
   int          stim_idx = 0;
   exp_t        sb_q[$];
   logic [35:0] m_a [0:N-1];
   logic [35:0] m_b [0:N-1];
   int          stuck_cnt;
   logic [15:0] stuck_first;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   oai_slice_stim_checker #(.NUM_VECTORS(N), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .mismatch_count(mcount), .first_fail_idx(ffidx), .fail_slice_mask(fmask),
      .a_o(a_o), .b_o(b_o), .c_i(c_q)
   );

   oai_slice_stim_checker #(.NUM_VECTORS(1), .SEED(SEED)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
      .mismatch_count(mcount1), .first_fail_idx(ffidx1), .fail_slice_mask(fmask1),
      .a_o(a1), .b_o(b1), .c_i(c1_q)
   );

   function automatic logic [35:0] tbRef(input logic [35:0] a, input logic [35:0] b);
      logic [35:0] r;
      for (int k = 0; k < 9; k++) begin
         int o;
         o = 4 * k;
         r[o]     = ~a[o];
         r[o + 1] = ~b[o];
         r[o + 2] = ~b[o + 1];
         r[o + 3] = ~((a[o + 1] | a[o + 2]) & (b[o + 1] | b[o + 2]) & (a[o + 3] | b[o + 3]));
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Netlist stand-in: registers its response so it arrives one cycle after the vector
   always @(posedge clk) begin
      logic [40:0] resp;
      resp = {5'b0, tbRef(a_o[35:0], b_o[35:0])};
      case (fault_mode)
         1: resp[3] = 1'b0;
         2: resp[38] = ~resp[38];
         3: begin
            if (run_idx == 7)   resp[17] = ~resp[17];
            if (run_idx == 20)  resp[0]  = ~resp[0];
            if (run_idx == 255) resp[35] = ~resp[35];
         end
         default: ;
      endcase
      c_q     <= resp;
      run_idx <= busy ? run_idx + 1 : 0;
      c1_q    <= {5'b0, tbRef(a1[35:0], b1[35:0])};
   end

   always @(negedge clk) begin
      if (!busy) begin
         stim_idx <= 0;
      end else begin
         if (chk_stim) begin
            if (stim_idx < N) begin
               checkOutput("stim_a", a_o, {5'b0, m_a[stim_idx]});
               checkOutput("stim_b", b_o, {5'b0, m_b[stim_idx]});
            end else begin
               checkOutput("drain_a", a_o, 41'd0);
               checkOutput("drain_b", b_o, 41'd0);
            end
         end
         stim_idx <= stim_idx + 1;
      end
   end

   // Scoreboard monitor: every done pulse must match the oldest pending run
   always @(negedge clk) begin
      if (done) begin
         checkOutput("done_expected", (sb_q.size() > 0), 1'b1);
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("done_cycle", cyc - e.start_cyc + 1, N + 2);
            checkOutput("pass", pass, e.pass);
            checkOutput("mismatch_count", mcount, e.count);
            checkOutput("first_fail_idx", ffidx, e.first);
            checkOutput("fail_slice_mask", fmask, e.mask);
         end
      end
   end

   task automatic applyStimulus(input logic p, input logic [15:0] cnt, input logic [15:0] first,
                                input logic [8:0] mask, output int s_cyc);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      s_cyc = cyc + 1;
      e.start_cyc = s_cyc;
      e.pass = p;
      e.count = cnt;
      e.first = first;
      e.mask = mask;
      sb_q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < N + 20) begin
         @(negedge clk);
         n++;
         if (done) seen = 1;
      end
      checkOutput(name, seen, 1'b1);
      @(negedge clk);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_done"}, done, 1'b0);
      checkOutput({tag, "_pass"}, pass, 1'b0);
      checkOutput({tag, "_count"}, mcount, 16'd0);
      checkOutput({tag, "_first"}, ffidx, 16'hFFFF);
      checkOutput({tag, "_mask"}, fmask, 9'd0);
      checkOutput({tag, "_a"}, a_o, 41'd0);
      checkOutput({tag, "_b"}, b_o, 41'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s;
      logic [71:0] lf;
      logic [35:0] r;

      rst_n  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;

      lf = SEED;
      stuck_cnt = 0;
      stuck_first = 16'hFFFF;
      for (int i = 0; i < N; i++) begin
         m_a[i] = lf[35:0];
         m_b[i] = lf[71:36];
         r = tbRef(m_a[i], m_b[i]);
         if (r[3]) begin
            stuck_cnt++;
            if (stuck_first == 16'hFFFF) stuck_first = 16'(i);
         end
         lf = {lf[70:0], lf[71] ^ lf[65] ^ lf[24] ^ lf[18]};
      end

      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;

      $display("[TB] correct netlist, stimulus sequence checked");
      chk_stim = 1;
      applyStimulus(1'b1, 16'd0, 16'hFFFF, 9'd0, s);
      waitDone("run_correct");
      chk_stim = 0;

      $display("[TB] start re-pulsed mid-run");
      applyStimulus(1'b1, 16'd0, 16'hFFFF, 9'd0, s);
      waitUntil(s + 4);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      waitUntil(s + 99);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      waitDone("run_repulse");

      $display("[TB] C[3] stuck at 0, model count %0d", stuck_cnt);
      fault_mode = 1;
      applyStimulus(stuck_cnt == 0, 16'(stuck_cnt), stuck_first,
                    (stuck_cnt > 0) ? 9'h001 : 9'h000, s);
      waitDone("run_stuck");

      $display("[TB] C[38] inverted");
      fault_mode = 2;
      applyStimulus(1'b1, 16'd0, 16'hFFFF, 9'd0, s);
      waitDone("run_unchecked");

      $display("[TB] single-vector flips at 7, 20 and 255");
      fault_mode = 3;
      applyStimulus(1'b0, 16'd3, 16'd7, 9'h111, s);
      waitDone("run_sparse");
      fault_mode = 0;
      repeat (4) @(negedge clk);
      checkOutput("hold_count", mcount, 16'd3);
      checkOutput("hold_pass", pass, 1'b0);

      $display("[TB] start held high across two runs");
      @(negedge clk);
      start = 1'b1;
      s = cyc + 1;
      sb_q.push_back('{s, 1'b1, 16'd0, 16'hFFFF, 9'd0});
      sb_q.push_back('{s + N + 3, 1'b1, 16'd0, 16'hFFFF, 9'd0});
      waitUntil(s + N + 3);
      start = 1'b0;
      waitDone("run_held");

      $display("[TB] reset abort at RUN cycle 10");
      applyStimulus(1'b1, 16'd0, 16'hFFFF, 9'd0, s);
      waitUntil(s + 9);
      rst_n = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      checkResetState("abort");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(1'b1, 16'd0, 16'hFFFF, 9'd0, s);
      @(negedge clk);
      checkOutput("rerun_first_a", a_o, {5'b0, SEED[35:0]});
      checkOutput("rerun_first_b", b_o, {5'b0, SEED[71:36]});
      waitDone("run_after_abort");

      $display("[TB] single-vector instance");
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      checkOutput("n1_busy_c1", busy1, 1'b1);
      checkOutput("n1_a_c1", a1, {5'b0, SEED[35:0]});
      checkOutput("n1_done_c1", done1, 1'b0);
      @(negedge clk);
      checkOutput("n1_busy_c2", busy1, 1'b1);
      checkOutput("n1_done_c2", done1, 1'b0);
      @(negedge clk);
      checkOutput("n1_busy_c3", busy1, 1'b0);
      checkOutput("n1_done_c3", done1, 1'b1);
      checkOutput("n1_pass", pass1, 1'b1);
      checkOutput("n1_count", mcount1, 16'd0);
      checkOutput("n1_first", ffidx1, 16'hFFFF);
      @(negedge clk);
      checkOutput("n1_done_pulse", done1, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("pending_results", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oai_slice_stim_checker.md
OAI_SLICE_STIM_CHECKER -- requirements
Module: oai_slice_stim_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 256, meaning vectors per run (1..65535).
REQ-002 The block SHALL have parameter SEED, default 72'h5A5A_0F0F_1234_89AB_CD, meaning LFSR start state (nonzero).
REQ-003 The block SHALL have port clk  in  1  meaning the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  in  1  meaning a run request, sampled only in IDLE.
REQ-006 The block SHALL have port busy  out  1  meaning a run is in progress.
REQ-007 The block SHALL have port done  out  1  meaning a one-cycle pulse at end of run.
REQ-008 The block SHALL have port pass  out  1  meaning the last run had zero mismatches.
REQ-009 The block SHALL have port mismatch_count  out  16  meaning failing vectors in the last run.
REQ-010 The block SHALL have port first_fail_idx  out  16  meaning the index of the first failing vector, 16'hFFFF if none.
REQ-011 The block SHALL have port fail_slice_mask  out  9  meaning a sticky OR of failing slices.
REQ-012 The block SHALL have port a_o  out  41  meaning the drive to the DUT A input.
REQ-013 The block SHALL have port b_o  out  41  meaning the drive to the DUT B inout (the checker is the sole driver).
REQ-014 The block SHALL have port c_i  in  41  meaning the DUT C response.

Function
REQ-015 The DUT model SHALL be 9 slices k=0..8, bits 4k..4k+3, defined as follows:
- e0=~A[4k]
- e1=~B[4k]
- e2=~B[4k+1]
- e3=~((A[4k+1]|A[4k+2])&(B[4k+1]|B[4k+2])&(A[4k+3]|B[4k+3])).
REQ-016 C[40:36] SHALL be unchecked, and a_o[40:36]/b_o[40:36] SHALL be driven 0.
REQ-017 The stimulus SHALL come from a 72-bit Fibonacci LFSR:
- polynomial x^72+x^66+x^25+x^19+1
- shift left, feedback XOR into bit 0
- a_o[35:0]=lfsr[35:0], b_o[35:0]=lfsr[71:36]
REQ-018 The FSM states SHALL be IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE→RUN on start=1
- RUN→DRAIN after NUM_VECTORS RUN cycles
- DRAIN→IDLE via DONE after one cycle each
REQ-019 On entering RUN, the LFSR SHALL load SEED, and mismatch_count, fail_slice_mask and first_fail_idx SHALL clear to 0, 0 and 16'hFFFF.
REQ-020 In RUN, one vector SHALL be presented per cycle, the LFSR SHALL advance every RUN cycle, and vector index i SHALL be presented in the (i+1)th RUN cycle.
REQ-021 The checker SHALL register the expected vector and compare c_i one cycle after presentation (latency 1), so the last compare occurs in DRAIN.
REQ-022 A vector SHALL fail if any checked bit differs; its slices SHALL be OR'd into fail_slice_mask.
REQ-023 mismatch_count SHALL saturate at 16'hFFFF, and first_fail_idx SHALL be written once per run.
REQ-024 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE; pass SHALL update in DONE to (mismatch_count==0).
REQ-025 start while not IDLE SHALL be ignored, and start held high SHALL relaunch one cycle after DONE.
REQ-026 done SHALL rise exactly NUM_VECTORS+2 cycles after the clock edge that samples start.
REQ-027 Results SHALL hold until the next RUN entry, and a_o/b_o SHALL be 0 outside RUN.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE, all outputs SHALL be 0 except first_fail_idx=16'hFFFF, and the LFSR SHALL equal SEED.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse, and the next run SHALL repeat the identical vector sequence.

Structure
REQ-030 A shared package netlist_tb_pkg SHALL hold WIDTH=41, SLICES=9, SLICE_W=4, the LFSR tap constants and the state enum.
REQ-031 The per-slice expected function SHALL live in a combinational sub-module oai_slice_ref, instantiated once with 36-bit A/B in and 36-bit expected out.

Verification
REQ-032 Correct DUT, NUM_VECTORS=256, start pulse -> done at cycle 258, pass=1, mismatch_count=0, first_fail_idx=16'hFFFF, mask=0.
REQ-033 DUT C[3] stuck-at-0 -> pass=0, fail_slice_mask=9'h001, mismatch_count equal to the model count of vectors with e3=1 for slice 0.
REQ-034 DUT C[38] inverted -> pass=1 (unchecked bit).
REQ-035 start re-pulsed at cycles 5 and 100 of a run -> ignored, single done at cycle 258.
REQ-036 rst_n low at RUN cycle 10, then a new start -> no done from the aborted run, and the first a_o/b_o equal the SEED slices again.
REQ-037 NUM_VECTORS=1, correct DUT -> busy for 2 cycles, done at cycle 3, pass=1.
